lbp_scan_scheduler: RTL and testbench

LBP_SCAN_SCHEDULER -- requirements
Module: lbp_scan_scheduler

---
 rtl/lbp_scan_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_lbp_scan_scheduler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lbp_scan_scheduler.sv
// -----------------------------------------------------------------------------
// lbp_scan_scheduler
//
// Purpose:
//   Walks every interior 3x3 window centre of an IMG_W x IMG_W grey image in
//   raster order (y = 1..IMG_W-2 outer, x = 1..IMG_W-2 inner). It fetches the
//   pixel columns that the shifting window datapath needs from the grey memory.
//   It tells the datapath when to shift, write and compute. It then presents
//   each LBP result address to a valid/ready sink.
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   synchronous, active-low reset
//   gray_ready in   grey memory can take a read request this cycle
//   gray_req   out  read request for gray_addr
//   gray_addr  out  pixel address {row, col}
//   pix_we     out  returned grey data goes into window row pix_row, right column
//   pix_row    out  window row 0/1/2 (top/mid/bottom), qualified by pix_we
//   win_shift  out  one-cycle pulse, window shifts one column left
//   calc_en    out  one-cycle pulse, datapath registers the LBP result
//   lbp_addr   out  result address {y, x} (nonzero only while lbp_valid)
//   lbp_valid  out  result valid, held until accepted
//   lbp_ready  in   sink accepts when lbp_valid && lbp_ready
//   finish     out  every interior result accepted; held until reset
// -----------------------------------------------------------------------------
module lbp_scan_scheduler #(
  parameter int IMG_W  = 128,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gray_ready,
  output logic              gray_req,
  output logic [ADDR_W-1:0] gray_addr,
  output logic              pix_we,
  output logic [1:0]        pix_row,
  output logic              win_shift,
  output logic              calc_en,
  output logic [ADDR_W-1:0] lbp_addr,
  output logic              lbp_valid,
  input  logic              lbp_ready,
  output logic              finish
);

  localparam int COL_W = ADDR_W / 2;
  localparam logic [COL_W-1:0] LAST = COL_W'(IMG_W - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_READ,
    S_WAIT,
    S_CALC,
    S_EMIT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [COL_W-1:0] r_x;
  logic [COL_W-1:0] r_y;
  logic [COL_W-1:0] r_fcol;     // image column currently being fetched
  logic [1:0]       r_row;      // window row of the next request
  logic             r_pix_we;
  logic [1:0]       r_pix_row;

  logic             w_req;
  logic             w_group_end;
  logic             w_last_col;
  logic             w_accept;
  logic [COL_W-1:0] w_row_addr;

  // A request only leaves while READ sees the memory ready; otherwise READ
  // stalls with r_row frozen.
  assign w_req       = (r_state == S_READ) && gray_ready;
  assign w_group_end = w_req && (r_row == 2'd2);
  // The right-hand window column is always x+1. Once it is fetched, the
  // window is complete, both when priming a row and in steady state.
  assign w_last_col  = (r_fcol == (r_x + COL_W'(1)));
  assign w_accept    = (r_state == S_EMIT) && lbp_ready;
  assign w_row_addr  = r_y - COL_W'(1) + COL_W'(r_row);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (gray_ready) w_state_next = S_SHIFT;
      S_SHIFT: w_state_next = S_READ;
      S_READ: begin
        if (w_group_end) begin
          w_state_next = w_last_col ? S_WAIT : S_SHIFT;
        end
      end
      S_WAIT:  w_state_next = S_CALC;
      S_CALC:  w_state_next = S_EMIT;
      S_EMIT: begin
        if (lbp_ready) begin
          w_state_next = ((r_x == LAST) && (r_y == LAST)) ? S_DONE : S_SHIFT;
        end
      end
      S_DONE:  w_state_next = S_DONE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Scan counters and the one-deep pix_we pipeline that tracks read latency
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_x       <= COL_W'(1);
      r_y       <= COL_W'(1);
      r_fcol    <= '0;
      r_row     <= '0;
      r_pix_we  <= 1'b0;
      r_pix_row <= '0;
    end else begin
      r_pix_we  <= w_req;
      r_pix_row <= w_req ? r_row : 2'd0;

      if (w_req) begin
        r_row <= w_group_end ? 2'd0 : r_row + 2'd1;
        if (w_group_end && !w_last_col) begin
          r_fcol <= r_fcol + COL_W'(1);
        end
      end

      if (w_accept) begin
        if (r_x != LAST) begin
          // Steady state: only the new right-hand column x+2 is needed.
          r_x    <= r_x + COL_W'(1);
          r_fcol <= r_x + COL_W'(2);
        end else if (r_y != LAST) begin
          // Row start: the window is primed from column 0 again.
          r_x    <= COL_W'(1);
          r_y    <= r_y + COL_W'(1);
          r_fcol <= '0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    gray_req  = 1'b0;
    gray_addr = '0;
    win_shift = 1'b0;
    calc_en   = 1'b0;
    lbp_valid = 1'b0;
    lbp_addr  = '0;
    finish    = 1'b0;
    case (r_state)
      S_SHIFT: win_shift = 1'b1;
      S_READ: begin
        gray_req  = gray_ready;
        gray_addr = {w_row_addr, r_fcol};
      end
      S_CALC:  calc_en = 1'b1;
      S_EMIT: begin
        lbp_valid = 1'b1;
        lbp_addr  = {r_y, r_x};
      end
      S_DONE:  finish = 1'b1;
      default: ;
    endcase
  end

  assign pix_we  = r_pix_we;
  assign pix_row = r_pix_row;

endmodule

// File: tb/tb_lbp_scan_scheduler.sv
// -----------------------------------------------------------------------------
// tb_lbp_scan_scheduler
//
// Purpose:
//   Self-checking bench for lbp_scan_scheduler on a 16x16 image. A scan-order
//   model builds the complete list of expected read requests and results. A
//   per-cycle compare process then checks every output against it. Directed
//   phases pin the model with hand-computed literals, and a randomized phase
//   toggles gray_ready and lbp_ready and pulses reset in the middle of a row.
// -----------------------------------------------------------------------------
module tb_lbp_scan_scheduler;

  localparam int IMG_W  = 16;
  localparam int ADDR_W = 8;
  localparam int N_WIN  = (IMG_W - 2) * (IMG_W - 2);

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              gray_ready = 1'b0;
  logic              lbp_ready = 1'b0;
  logic              gray_req;
  logic [ADDR_W-1:0] gray_addr;
  logic              pix_we;
  logic [1:0]        pix_row;
  logic              win_shift;
  logic              calc_en;
  logic [ADDR_W-1:0] lbp_addr;
  logic              lbp_valid;
  logic              finish;

  always #5 clk = ~clk;

  lbp_scan_scheduler #(.IMG_W(IMG_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .gray_ready(gray_ready),
    .gray_req  (gray_req),
    .gray_addr (gray_addr),
    .pix_we    (pix_we),
    .pix_row   (pix_row),
    .win_shift (win_shift),
    .calc_en   (calc_en),
    .lbp_addr  (lbp_addr),
    .lbp_valid (lbp_valid),
    .lbp_ready (lbp_ready),
    .finish    (finish)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Scan-order model: expected request stream and expected result stream
  // ---------------------------------------------------------------------------
  typedef struct {
    int addr;
    int row;
    bit grp_end;
    bit win_end;
  } req_t;

  req_t rq[$];
  int   wq[$];
  bit   wrow[$];

  function automatic void build_model();
    req_t e;
    rq.delete(); wq.delete(); wrow.delete();
    for (int y = 1; y <= IMG_W - 2; y++) begin
      for (int x = 1; x <= IMG_W - 2; x++) begin
        for (int c = (x == 1 ? 0 : x + 1); c <= x + 1; c++) begin
          for (int r = 0; r < 3; r++) begin
            e.addr    = (y - 1 + r) * IMG_W + c;
            e.row     = r;
            e.grp_end = (r == 2);
            e.win_end = (r == 2) && (c == x + 1);
            rq.push_back(e);
          end
        end
        wq.push_back(y * IMG_W + x);
        wrow.push_back(x == 1);
      end
    end
  endfunction

  // Model state
  bit   m_idle = 1'b0, m_done = 1'b0, m_shift_exp = 1'b0, m_valid = 1'b0;
  bit   m_prev_req = 1'b0, just_reset = 1'b0, new_win = 1'b1;
  int   m_prev_row = 0, reads_left = 0, calc_cd = 0;
  int   cyc = 0, shift_cyc = 0, stalls = 0, first_valid_cyc = -1;
  int   req_log[$], acc_cyc[$], acc_addr[$];
  bit   e_req, e_acc, n_shift, e_calc;
  req_t cur;

  always @(negedge clk) begin
    if (just_reset) begin
      chk("reset_outputs_zero",
          {gray_req, gray_addr, pix_we, pix_row, win_shift, calc_en,
           lbp_addr, lbp_valid, finish}, 0);
    end

    e_req = (reads_left > 0) && gray_ready;
    chk("gray_req", gray_req, e_req);
    cur = '{addr: 0, row: 0, grp_end: 1'b0, win_end: 1'b0};
    if (e_req && rq.size() > 0) cur = rq.pop_front();
    if (e_req && gray_req) chk("gray_addr", gray_addr, cur.addr);
    if (gray_req) req_log.push_back(int'(gray_addr));

    chk("pix_we", pix_we, m_prev_req);
    if (m_prev_req && pix_we) chk("pix_row", pix_row, m_prev_row);

    chk("win_shift", win_shift, m_shift_exp);
    e_calc = (calc_cd == 1);
    chk("calc_en", calc_en, e_calc);
    chk("lbp_valid", lbp_valid, m_valid);
    if (m_valid && lbp_valid && wq.size() > 0) chk("lbp_addr", lbp_addr, wq[0]);
    chk("finish", finish, m_done);

    // Latency bookkeeping: window start is the DUT's first shift of the window.
    if (win_shift && new_win) begin
      shift_cyc = cyc;
      stalls    = 0;
      new_win   = 1'b0;
    end
    if (reads_left > 0 && !gray_ready) stalls++;
    if (m_valid && !lbp_ready) stalls++;

    if (lbp_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (lbp_valid && lbp_ready) begin
      acc_cyc.push_back(cyc);
      acc_addr.push_back(int'(lbp_addr));
    end

    // Advance the model
    e_acc   = m_valid && lbp_ready;
    n_shift = 1'b0;
    if (m_idle && gray_ready) begin
      n_shift = 1'b1;
      m_idle  = 1'b0;
    end
    if (e_req && cur.grp_end && !cur.win_end) n_shift = 1'b1;
    if (calc_cd > 0) calc_cd--;
    if (e_req && cur.win_end) calc_cd = 2;
    if (e_calc) m_valid = 1'b1;
    if (e_acc && wq.size() > 0) begin
      chk("window_latency", cyc - shift_cyc + 1, (wrow[0] ? 15 : 7) + stalls);
      void'(wq.pop_front());
      void'(wrow.pop_front());
      m_valid = 1'b0;
      new_win = 1'b1;
      if (wq.size() == 0) m_done = 1'b1;
      else n_shift = 1'b1;
    end
    if (m_shift_exp) reads_left = 3;
    else if (e_req) reads_left--;
    m_prev_req  = e_req;
    m_prev_row  = cur.row;
    m_shift_exp = n_shift;
    just_reset  = 1'b0;
    cyc++;

    if (!reset) begin
      build_model();
      m_idle = 1'b1; m_done = 1'b0; m_shift_exp = 1'b0; m_valid = 1'b0;
      m_prev_req = 1'b0; m_prev_row = 0; reads_left = 0; calc_cd = 0;
      new_win = 1'b1; stalls = 0; shift_cyc = 0; first_valid_cyc = -1;
      req_log.delete(); acc_cyc.delete(); acc_addr.delete();
      just_reset = 1'b1;
      cyc = 0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  bit rand_mode = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_mode) begin
      gray_ready = ($urandom_range(0, 99) < 75);
      lbp_ready  = ($urandom_range(0, 99) < 60);
    end
  endtask

  int first_addrs [9] = '{0, 16, 32, 1, 17, 33, 2, 18, 34};
  int second_addrs[3] = '{3, 19, 35};

  initial begin
    repeat (3) step();

    // Phase A: no stalls, full scan
    reset = 1'b1; gray_ready = 1'b1; lbp_ready = 1'b1;
    for (int k = 0; k < 5000 && !m_done; k++) step();
    chk("A_done_reached", m_done, 1);
    for (int i = 0; i < 9; i++) chk("A_first_addrs", req_log[i], first_addrs[i]);
    for (int i = 0; i < 3; i++) chk("A_second_win_addrs", req_log[9 + i], second_addrs[i]);
    chk("A_first_valid_cycle", first_valid_cyc, 15);
    chk("A_first_lbp_addr", acc_addr[0], 17);
    chk("A_second_lbp_addr", acc_addr[1], 18);
    chk("A_steady_interval", acc_cyc[1] - acc_cyc[0], 7);
    chk("A_rowstart_interval", acc_cyc[14] - acc_cyc[13], 15);
    chk("A_accept_count", acc_addr.size(), N_WIN);
    chk("A_last_lbp_addr", acc_addr[N_WIN - 1], (IMG_W - 2) * IMG_W + (IMG_W - 2));
    repeat (5) step();
    chk("A_finish_sticky", finish, 1);

    // Phase B: gray memory stall of 5 cycles during the r=1 request
    reset = 1'b0;
    step();
    reset = 1'b1;
    for (int k = 0; k < 100 && req_log.size() < 1; k++) step();
    gray_ready = 1'b0;
    repeat (5) step();
    gray_ready = 1'b1;
    for (int k = 0; k < 100 && acc_addr.size() < 1; k++) step();
    chk("B_stalled_first_valid", first_valid_cyc, 20);
    for (int i = 0; i < 3; i++) chk("B_addrs_unchanged", req_log[i], first_addrs[i]);

    // Phase C: sink holds off for 10 cycles in EMIT
    lbp_ready = 1'b0;
    for (int k = 0; k < 100 && !lbp_valid; k++) step();
    repeat (10) step();
    chk("C_no_accept_while_held", acc_addr.size(), 1);
    lbp_ready = 1'b1;
    for (int k = 0; k < 100 && acc_addr.size() < 2; k++) step();
    chk("C_single_accept_addr", acc_addr[1], 18);

    // Phase D: random handshakes, mid-row reset, then scan to completion
    rand_mode = 1'b1;
    repeat (300) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    for (int k = 0; k < 500 && req_log.size() < 1; k++) step();
    chk("D_restart_addr", req_log[0], 0);
    for (int k = 0; k < 40000 && !m_done; k++) step();
    chk("D_done_reached", m_done, 1);
    chk("D_accept_count", acc_addr.size(), N_WIN);
    chk("D_last_lbp_addr", acc_addr[N_WIN - 1], (IMG_W - 2) * IMG_W + (IMG_W - 2));
    repeat (5) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
